// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: start/done sequencer for the shared register-file + ALU datapath.
// A job seeds R[base] and R[base+1], then runs COUNT recurrence steps
// R[base+k+2] = R[base+k] op R[base+k+1], one step per cycle.
//
// Handshake: start is a level request sampled only in IDLE. There is no ready.
// An accepted start shows up as busy=1 in the next cycle. A rejected start shows
// up as a one-cycle err pulse in the next cycle. A start seen in any other state
// is dropped and must be re-presented once the block is back in IDLE.
module rf_seq_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    input  logic [2:0]        op_in,
    input  logic              hold,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    output logic [ADDR_W-1:0] waddr,
    output logic              we,
    output logic              wsel,
    output logic [DATA_W-1:0] wseed,
    output logic [2:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED0 = 3'd1,
        S_SEED1 = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0]   ONE_EXT   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A1        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A2        = ADDR_W'(2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] base_q, count_q;
    logic [DATA_W-1:0] seed_a_q, seed_b_q;
    logic [2:0]        op_q;
    logic              err_q;
    logic              accept, reject;

    // Highest register the requested job would write, computed one bit wider so
    // that base+count+1 cannot wrap past the top of the file.
    logic [ADDR_W:0]   top_addr;
    logic              start_bad;
    assign top_addr  = {1'b0, base_addr} + {1'b0, count} + ONE_EXT;
    assign start_bad = (count == '0) || (top_addr > LAST_ADDR);

    assign err       = err_q;
    assign alu_op    = op_q;
    assign dbg_state = state_q;

    // State, step counter, job latches and the registered err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            base_q   <= '0;
            count_q  <= '0;
            seed_a_q <= '0;
            seed_b_q <= '0;
            op_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= reject;
            if (accept) begin
                base_q   <= base_addr;
                count_q  <= count;
                seed_a_q <= seed_a;
                seed_b_q <= seed_b;
                op_q     <= op_in;
            end
        end
    end

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        accept  = 1'b0;
        reject  = 1'b0;
        raddr1  = '0;
        raddr2  = '0;
        waddr   = '0;
        we      = 1'b0;
        wsel    = 1'b0;
        wseed   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        k_d     = '0;
                        state_d = S_SEED0;
                    end
                end
            end
            S_SEED0: begin
                busy  = 1'b1;
                waddr = base_q;
                wseed = seed_a_q;
                we    = !hold;
                if (!hold) state_d = S_SEED1;
            end
            S_SEED1: begin
                busy  = 1'b1;
                waddr = base_q + A1;
                wseed = seed_b_q;
                we    = !hold;
                if (!hold) state_d = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                raddr1 = base_q + k_q;
                raddr2 = base_q + k_q + A1;
                waddr  = base_q + k_q + A2;
                wsel   = 1'b1;
                we     = !hold;
                if (!hold) begin
                    k_d = k_q + A1;
                    if (k_q == count_q - A1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Testbench for rf_seq_ctrl: a per-cycle vector table plus hand-written
// sequences for boundary, ignored-start, reference-model and reset cases.
// A small register file + ALU lives here so written values can be checked.
module tb_rf_seq_ctrl;

    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [5:0]  count;
    logic [31:0] seed_a;
    logic [31:0] seed_b;
    logic [2:0]  op_in;
    logic        hold;
    logic [5:0]  raddr1, raddr2, waddr;
    logic        we, wsel;
    logic [31:0] wseed;
    logic [2:0]  alu_op;
    logic        busy, done, err;
    logic [2:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    rf_seq_ctrl #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .seed_a(seed_a), .seed_b(seed_b), .op_in(op_in),
        .hold(hold), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr),
        .we(we), .wsel(wsel), .wseed(wseed), .alu_op(alu_op), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- register file + ALU model ----------------
    logic [31:0] rf [64];
    logic        rf_clr = 1'b0;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 64; i++) rf[i] <= 32'd0;
        end else if (we) begin
            rf[waddr] <= wsel ? alu(rf[raddr1], rf[raddr2], alu_op) : wseed;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic        hd;
        logic [5:0]  b;
        logic [5:0]  c;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [2:0]  op;
        logic        e_busy, e_done, e_err, e_we, e_wsel;
        logic [5:0]  e_r1, e_r2, e_w;
        logic [31:0] e_wseed;
        logic [2:0]  e_op;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int st, input int hd, input int b, input int c,
                                input int sa, input int sb, input int op,
                                input int bz, input int dn, input int er, input int w_e,
                                input int ws, input int r1, input int r2, input int w,
                                input int wsd, input int eop);
        vec_t v;
        v.st = 1'(st);      v.hd = 1'(hd);      v.b = 6'(b);        v.c = 6'(c);
        v.sa = 32'(sa);     v.sb = 32'(sb);     v.op = 3'(op);
        v.e_busy = 1'(bz);  v.e_done = 1'(dn);  v.e_err = 1'(er);
        v.e_we = 1'(w_e);   v.e_wsel = 1'(ws);
        v.e_r1 = 6'(r1);    v.e_r2 = 6'(r2);    v.e_w = 6'(w);
        v.e_wseed = 32'(wsd); v.e_op = 3'(eop);
        return v;
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            start = vecs[i].st;  hold = vecs[i].hd;  base_addr = vecs[i].b;
            count = vecs[i].c;   seed_a = vecs[i].sa; seed_b = vecs[i].sb;
            op_in = vecs[i].op;
            #1;
            check($sformatf("v%0d busy", i),   32'(busy),   32'(vecs[i].e_busy));
            check($sformatf("v%0d done", i),   32'(done),   32'(vecs[i].e_done));
            check($sformatf("v%0d err", i),    32'(err),    32'(vecs[i].e_err));
            check($sformatf("v%0d we", i),     32'(we),     32'(vecs[i].e_we));
            check($sformatf("v%0d wsel", i),   32'(wsel),   32'(vecs[i].e_wsel));
            check($sformatf("v%0d raddr1", i), 32'(raddr1), 32'(vecs[i].e_r1));
            check($sformatf("v%0d raddr2", i), 32'(raddr2), 32'(vecs[i].e_r2));
            check($sformatf("v%0d waddr", i),  32'(waddr),  32'(vecs[i].e_w));
            check($sformatf("v%0d wseed", i),  wseed,       vecs[i].e_wseed);
            check($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].e_op));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_rf();
        @(negedge clk);
        rf_clr = 1'b1;
        @(negedge clk);
        rf_clr = 1'b0;
    endtask

    // Presents one start; returns at the negedge of the first SEED0 cycle.
    task automatic start_job(input int b, input int c, input int sa, input int sb,
                             input logic [2:0] op);
        @(negedge clk);
        start = 1'b1; base_addr = 6'(b); count = 6'(c);
        seed_a = 32'(sa); seed_b = 32'(sb); op_in = op;
        @(negedge clk);
        start = 1'b0; base_addr = '0; count = '0; seed_a = '0; seed_b = '0; op_in = '0;
    endtask

    // Runs a job to completion, recording the last write address seen.
    task automatic run_boundary(input int b, input int exp_last, input string nm);
        logic [5:0] last_w;
        logic       seen;
        last_w = '0;
        seen   = 1'b0;
        start_job(b, 3, 2, 3, ADD);
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (we) last_w = waddr;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({nm, " done_seen"}, 32'(seen), 32'd1);
        check({nm, " last_waddr"}, 32'(last_w), 32'(exp_last));
        check({nm, " rf_last"}, rf[exp_last], 32'd13);
    endtask

    int t1_lo, t2_lo, t3_lo, t9_lo, t_end;
    int dc_snap;
    logic found;

    initial begin
        // T1: base 0, count 3, seeds 1/1, ADD
        t1_lo = vecs.size();
        vecs.push_back(mk(1,0, 0,3, 1,1, ADD, 0,0,0,0,0, 0,0,0, 0, 0));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,0, 0,0,0, 1, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,0, 0,0,1, 1, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 0,1,2, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 1,2,3, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 2,3,4, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   0,1,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   0,0,0,0,0, 0,0,0, 0, ADD));
        // T2: same job, hold for two cycles at step k=1
        t2_lo = vecs.size();
        vecs.push_back(mk(1,0, 0,3, 1,1, ADD, 0,0,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,0, 0,0,0, 1, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,0, 0,0,1, 1, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 0,1,2, 0, ADD));
        vecs.push_back(mk(0,1, 0,0, 0,0, 0,   1,0,0,0,1, 1,2,3, 0, ADD));
        vecs.push_back(mk(0,1, 0,0, 0,0, 0,   1,0,0,0,1, 1,2,3, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 1,2,3, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   1,0,0,1,1, 2,3,4, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   0,1,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,   0,0,0,0,0, 0,0,0, 0, ADD));
        // T3/T5: out-of-range and zero-count rejects; latches keep ADD
        t3_lo = vecs.size();
        vecs.push_back(mk(1,0, 60,3, 9,9, SUB, 0,0,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   0,0,1,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   0,0,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(1,0, 0,0,  9,9, SUB, 0,0,0,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   0,0,1,0,0, 0,0,0, 0, ADD));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   0,0,0,0,0, 0,0,0, 0, ADD));
        // T9: hold in IDLE/SEED0/SEED1/DONE; base 40, count 1, 6/7, SUB
        t9_lo = vecs.size();
        vecs.push_back(mk(1,1, 40,1, 6,7, SUB, 0,0,0,0,0, 0,0,0,   0, ADD));
        vecs.push_back(mk(0,1, 0,0,  0,0, 0,   1,0,0,0,0, 0,0,40,  6, SUB));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   1,0,0,1,0, 0,0,40,  6, SUB));
        vecs.push_back(mk(0,1, 0,0,  0,0, 0,   1,0,0,0,0, 0,0,41,  7, SUB));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   1,0,0,1,0, 0,0,41,  7, SUB));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   1,0,0,1,1, 40,41,42, 0, SUB));
        vecs.push_back(mk(0,1, 0,0,  0,0, 0,   0,1,0,0,0, 0,0,0,   0, SUB));
        vecs.push_back(mk(0,0, 0,0,  0,0, 0,   0,0,0,0,0, 0,0,0,   0, SUB));
        t_end = vecs.size();

        start = 0; hold = 0; base_addr = '0; count = '0;
        seed_a = '0; seed_b = '0; op_in = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset dbg_state", 32'(dbg_state), 32'd0);
        check("reset outputs", 32'({busy, done, err, we, wsel, raddr1, raddr2, waddr, alu_op}), 32'd0);
        rst_n = 1'b1;
        clear_rf();

        run_table(t1_lo, t2_lo);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1 R%0d", i), rf[i], (i == 0) ? 32'd1 : (i == 1) ? 32'd1 :
                                                 (i == 2) ? 32'd2 : (i == 3) ? 32'd3 : 32'd5);
        end

        clear_rf();
        run_table(t2_lo, t3_lo);
        check("t2 R2", rf[2], 32'd2);
        check("t2 R3", rf[3], 32'd3);
        check("t2 R4", rf[4], 32'd5);
        check("t2 R5 untouched", rf[5], 32'd0);

        run_table(t3_lo, t9_lo);

        clear_rf();
        run_table(t9_lo, t_end);
        check("t9 R40", rf[40], 32'd6);
        check("t9 R41", rf[41], 32'd7);
        check("t9 R42", rf[42], 32'hFFFF_FFFF);

        // T4: top-of-file boundaries
        clear_rf();
        run_boundary(58, 62, "t4 base58");
        run_boundary(59, 63, "t4 base59");

        // T6: start during RUN and during DONE is ignored
        clear_rf();
        start_job(20, 2, 4, 5, ADD);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; base_addr = 6'd0; count = 6'd1;
        seed_a = 32'd9; seed_b = 32'd9; op_in = SUB;
        #1;
        check("t6 run k0 raddr1", 32'(raddr1), 32'd20);
        @(negedge clk); #1;
        check("t6 run k1 raddr1", 32'(raddr1), 32'd21);
        check("t6 run k1 alu_op", 32'(alu_op), 32'(ADD));
        @(negedge clk); #1;
        check("t6 done", 32'(done), 32'd1);
        @(negedge clk); #1;
        check("t6 idle after done", 32'({busy, we}), 32'd0);
        start = 1'b0; base_addr = '0; count = '0; seed_a = '0; seed_b = '0; op_in = '0;
        check("t6 R20", rf[20], 32'd4);
        check("t6 R21", rf[21], 32'd5);
        check("t6 R22", rf[22], 32'd9);
        check("t6 R23", rf[23], 32'd14);

        // T8: per-cycle address triples vs reference; base 10, count 5, SUB
        clear_rf();
        exp_q.push_back({6'd0, 6'd0, 6'd10});
        exp_q.push_back({6'd0, 6'd0, 6'd11});
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({6'(10 + k), 6'(11 + k), 6'(12 + k)});
        end
        start_job(10, 5, 100, 7, SUB);
        for (int c = 0; c < 7; c++) begin
            logic [17:0] e;
            #1;
            e = exp_q.pop_front();
            check($sformatf("t8 triple c%0d", c), 32'({raddr1, raddr2, waddr}), 32'(e));
            check($sformatf("t8 we c%0d", c), 32'(we), 32'd1);
            @(negedge clk);
        end
        #1;
        check("t8 done", 32'(done), 32'd1);
        begin
            int ev[7] = '{100, 7, 93, -86, 179, -265, 444};
            for (int i = 0; i < 7; i++) begin
                check($sformatf("t8 R%0d", 10 + i), rf[10 + i], 32'(ev[i]));
            end
        end

        // T7: asynchronous reset in RUN step k=2
        start_job(0, 5, 1, 1, ADD);
        dc_snap = done_cnt;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (wsel && raddr1 == 6'd2) found = 1'b1;
            else @(negedge clk);
        end
        check("t7 reached k2", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7 outputs at reset",
              32'({busy, done, err, we, wsel, raddr1, raddr2, waddr, alu_op}), 32'd0);
        check("t7 wseed at reset", wseed, 32'd0);
        check("t7 state at reset", 32'(dbg_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t7 no done", 32'(done_cnt), 32'(dc_snap));
        check("t7 idle after release", 32'(dbg_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
